mic_capture_ctrl: RTL and testbench



---
 rtl/mic_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mic_capture_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_capture_ctrl.sv
// mic_capture_ctrl: PDM microphone capture sequencer.
// Drives mic_clk from the divider tick, samples PDM data on the falling
// mic_clk edge, counts ones over DECIM bits and offers each count on a
// valid/ready output register. A start/stop FSM discards WARMUP windows
// after start and parks mic_clk low before returning to idle.
// Build macro MIC_STEREO_EN: also sample a right channel on the rising
// mic_clk edge; pcm_data becomes {right, left}.
//
// Output handshake: a sample transfers on any cycle with pcm_valid &&
// pcm_ready. pcm_data is held stable while pcm_valid && !pcm_ready, and
// pcm_valid only drops after a transfer that is not replaced by a new load.
module mic_capture_ctrl #(
   parameter int DECIM  = 64,
   parameter int WARMUP = 4,
   parameter int CW     = $clog2(DECIM + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick,
   input  logic            start,
   input  logic            stop,
   output logic            busy,
   output logic            mic_clk,
   input  logic            mic_data,
   output logic            pcm_valid,
   input  logic            pcm_ready,
`ifdef MIC_STEREO_EN
   output logic [2*CW-1:0] pcm_data,
`else
   output logic [CW-1:0]   pcm_data,
`endif
   output logic            overrun,
   output logic [1:0]      dbg_state
);

`ifdef MIC_STEREO_EN
   localparam int OW = 2 * CW;
`else
   localparam int OW = CW;
`endif
   // Warm-up counter needs at least one bit even when warm-up is disabled.
   localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WARMUP   = 2'd1,
      S_RUN      = 2'd2,
      S_STOPPING = 2'd3
   } state_t;

   state_t          state_q;
   logic            mic_clk_q;
   logic [CW-1:0]   bit_cnt_q;
   logic [CW-1:0]   left_acc_q;
   logic [WW-1:0]   warm_cnt_q;
   logic            pcm_valid_q;
   logic [OW-1:0]   pcm_data_q;
   logic            overrun_q;
`ifdef MIC_STEREO_EN
   logic [CW-1:0]   right_acc_q;
   logic [CW-1:0]   right_sum_d;
   logic            rise_tick;
`endif

   logic            sampling;
   logic            fall_tick;
   logic [CW-1:0]   left_sum_d;
   logic [CW-1:0]   bit_cnt_d;
   logic            win_done;
   logic            offer;
   logic            load;
   logic [OW-1:0]   result_d;

   // Sample strobes, window completion and the result that would be offered.
   always_comb begin
      sampling   = (state_q == S_WARMUP) || (state_q == S_RUN);
      fall_tick  = sampling && tick && mic_clk_q;
      left_sum_d = left_acc_q + CW'(mic_data);
      bit_cnt_d  = bit_cnt_q + 1'b1;
      // The completing bit is folded into the count via left_sum_d.
      win_done   = fall_tick && (bit_cnt_q == CW'(DECIM - 1));
      offer      = win_done && (state_q == S_RUN);
      load       = offer && (!pcm_valid_q || pcm_ready);
`ifdef MIC_STEREO_EN
      rise_tick   = sampling && tick && !mic_clk_q;
      right_sum_d = right_acc_q + CW'(mic_data);
      // All right bits of the window were taken on earlier rising ticks.
      result_d    = {right_acc_q, left_sum_d};
`else
      result_d    = left_sum_d;
`endif
   end

   // Control FSM, accumulators and the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mic_clk_q   <= 1'b0;
         bit_cnt_q   <= '0;
         left_acc_q  <= '0;
         warm_cnt_q  <= '0;
         pcm_valid_q <= 1'b0;
         pcm_data_q  <= '0;
         overrun_q   <= 1'b0;
`ifdef MIC_STEREO_EN
         right_acc_q <= '0;
`endif
      end else begin
         // Output register runs regardless of state.
         if (load) begin
            pcm_data_q  <= result_d;
            pcm_valid_q <= 1'b1;
         end else if (pcm_valid_q && pcm_ready) begin
            pcm_valid_q <= 1'b0;
         end
         if (offer && !load) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               mic_clk_q <= 1'b0;
               if (start) begin
                  state_q    <= (WARMUP > 0) ? S_WARMUP : S_RUN;
                  overrun_q  <= 1'b0;
                  bit_cnt_q  <= '0;
                  left_acc_q <= '0;
                  warm_cnt_q <= '0;
`ifdef MIC_STEREO_EN
                  right_acc_q <= '0;
`endif
               end
            end
            S_WARMUP, S_RUN: begin
               if (tick) begin
                  mic_clk_q <= !mic_clk_q;
               end
               if (win_done) begin
                  bit_cnt_q  <= '0;
                  left_acc_q <= '0;
               end else if (fall_tick) begin
                  bit_cnt_q  <= bit_cnt_d;
                  left_acc_q <= left_sum_d;
               end
`ifdef MIC_STEREO_EN
               if (win_done) begin
                  right_acc_q <= '0;
               end else if (rise_tick) begin
                  right_acc_q <= right_sum_d;
               end
`endif
               if (win_done && (state_q == S_WARMUP)) begin
                  warm_cnt_q <= warm_cnt_q + 1'b1;
                  if (warm_cnt_q == WW'(WARMUP - 1)) begin
                     state_q <= S_RUN;
                  end
               end
               // Stop overrides the warm-up exit; a completing window is
               // still delivered by the output register above.
               if (stop) begin
                  state_q <= S_STOPPING;
               end
            end
            S_STOPPING: begin
               bit_cnt_q  <= '0;
               left_acc_q <= '0;
`ifdef MIC_STEREO_EN
               right_acc_q <= '0;
`endif
               if (!mic_clk_q) begin
                  state_q <= S_IDLE;
               end else if (tick) begin
                  mic_clk_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign mic_clk   = mic_clk_q;
   assign pcm_valid = pcm_valid_q;
   assign pcm_data  = pcm_data_q;
   assign overrun   = overrun_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// tb_mic_capture_ctrl: directed bench for mic_capture_ctrl with
// DECIM=8, WARMUP=2 and a divider tick every 4 clk.
module tb_mic_capture_ctrl;

`ifdef MIC_STEREO_EN
   localparam int OW = 8;
`else
   localparam int OW = 4;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          tick = 1'b0;
   logic          start;
   logic          stop;
   logic          busy;
   logic          mic_clk;
   logic          mic_data;
   logic          pcm_valid;
   logic          pcm_ready;
   logic [OW-1:0] pcm_data;
   logic          overrun;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int n_ticks = 0;
   int tick_ph = 0;
   int cyc = 0;
   int last_rise = 0;
   int last_period = 0;
   logic mic_prev = 1'b0;

   logic [OW-1:0] exp_q[$];

   typedef struct {
      logic [7:0] lp;
      logic [7:0] rp;
      logic [3:0] em;
      logic [7:0] es;
   } vec_t;

   mic_capture_ctrl #(.DECIM(8), .WARMUP(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .mic_clk   (mic_clk),
      .mic_data  (mic_data),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .pcm_data  (pcm_data),
      .overrun   (overrun),
      .dbg_state (dbg_state)
   );

   // Clock and divider tick (one pulse every 4 clk).
   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_ph = (tick_ph + 1) % 4;
      tick = (tick_ph == 0);
   end

   // mic_clk period tracker (in clk cycles between rising edges).
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (mic_clk && !mic_prev) begin
         last_period <= cyc - last_rise;
         last_rise <= cyc;
      end
      mic_prev <= mic_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] pick(input logic [3:0] em, input logic [7:0] es);
`ifdef MIC_STEREO_EN
      pick = es;
      if (em == 4'hF) pick = es;
`else
      pick = em;
      if (es == 8'hFF) pick = em;
`endif
   endfunction

   // Scoreboard: every transfer must match the oldest expected sample.
   always @(negedge clk) begin
      #2;
      if (!rst && pcm_valid && pcm_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample act=%0h exp=none", pcm_data);
         end else begin
            check("sample", pcm_data, exp_q.pop_front());
         end
      end
   end

   // Advance to the next cycle whose upcoming edge carries a tick.
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!tick && n < 16);
      if (!tick) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout act=%0d exp=tick", n);
      end
      n_ticks++;
   endtask

   // Microphone model: right bit on rising ticks, left bit on falling ticks.
   task automatic drive_bits(input logic [7:0] lp, input logic [7:0] rp, input int nb);
      for (int b = 0; b < nb; b++) begin
         wait_tick();
         if (!mic_clk) begin
            mic_data = rp[b];
            wait_tick();
         end
         mic_data = lp[b];
      end
   endtask

   // Start pulse placed so the first post-start tick is seen by drive_bits.
   task automatic do_start(input logic with_stop);
      wait_tick();
      @(negedge clk);
      #1;
      start = 1'b1;
      stop = with_stop;
      @(negedge clk);
      #1;
      start = 1'b0;
      stop = 1'b0;
      n_ticks = 0;
   endtask

   initial begin
      vec_t vecs[8];
      logic [OW-1:0] e;
      int n;
      vecs[0] = '{lp: 8'hFF, rp: 8'h00, em: 4'd8, es: 8'h08};
      vecs[1] = '{lp: 8'h00, rp: 8'hFF, em: 4'd0, es: 8'h80};
      vecs[2] = '{lp: 8'h55, rp: 8'hAA, em: 4'd4, es: 8'h44};
      vecs[3] = '{lp: 8'h55, rp: 8'h55, em: 4'd4, es: 8'h44};
      vecs[4] = '{lp: 8'h01, rp: 8'h00, em: 4'd1, es: 8'h01};
      vecs[5] = '{lp: 8'h80, rp: 8'hFF, em: 4'd1, es: 8'h81};
      vecs[6] = '{lp: 8'h7F, rp: 8'h03, em: 4'd7, es: 8'h27};
      vecs[7] = '{lp: 8'hAA, rp: 8'h55, em: 4'd4, es: 8'h44};

      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      mic_data = 1'b0;
      pcm_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;

      // Reset state.
      check("rst_busy", busy, 0);
      check("rst_mic_clk", mic_clk, 0);
      check("rst_valid", pcm_valid, 0);
      check("rst_data", pcm_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_state", dbg_state, 0);

      // Idle ignores stop and tick.
      stop = 1'b1;
      @(negedge clk);
      #1;
      stop = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_mic_clk", mic_clk, 0);

      // Start, two discarded windows, first sample after the 48th tick.
      do_start(1'b0);
      check("start_busy", busy, 1);
      check("start_state", dbg_state, 1);
      drive_bits(8'hFF, 8'hFF, 8);
      drive_bits(8'hFF, 8'hFF, 8);
      e = pick(4'd8, 8'h08);
      drive_bits(8'hFF, 8'h00, 8);
      exp_q.push_back(e);
      check("first_valid_early", pcm_valid, 0);
      check("first_tick_count", n_ticks, 48);
      @(negedge clk);
      #1;
      check("first_valid", pcm_valid, 1);
      check("first_data", pcm_data, e);
      check("run_state", dbg_state, 2);
      check("mic_clk_period", last_period, 8);

      // Table of window patterns, consumer always ready.
      for (int i = 0; i < 8; i++) begin
         drive_bits(vecs[i].lp, vecs[i].rp, 8);
         exp_q.push_back(pick(vecs[i].em, vecs[i].es));
      end
      check("no_overrun", overrun, 0);
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      check("valid_after_xfer", pcm_valid, 0);
      pcm_ready = 1'b0;

      // Back-pressure across two completions.
      e = pick(4'd3, 8'h03);
      drive_bits(8'h07, 8'h00, 8);
      exp_q.push_back(e);
      @(negedge clk);
      #1;
      check("held_valid", pcm_valid, 1);
      check("held_data", pcm_data, e);
      check("held_no_overrun", overrun, 0);
      drive_bits(8'hFF, 8'hFF, 8);
      @(negedge clk);
      #1;
      check("ovr_data_kept", pcm_data, e);
      check("ovr_set", overrun, 1);
      check("ovr_valid", pcm_valid, 1);
      pcm_ready = 1'b1;
      @(negedge clk);
      #1;
      check("ovr_valid_drop", pcm_valid, 0);
      check("ovr_sticky", overrun, 1);

      // Stop three bits into a window with mic_clk high.
      drive_bits(8'h07, 8'h00, 3);
      wait_tick();
      check("stop_pre_rise", mic_clk, 0);
      mic_data = 1'b0;
      @(negedge clk);
      #1;
      check("stop_mic_hi", mic_clk, 1);
      stop = 1'b1;
      @(negedge clk);
      #1;
      stop = 1'b0;
      check("stopping_state", dbg_state, 3);
      check("stopping_mic_hi", mic_clk, 1);
      wait_tick();
      @(negedge clk);
      #1;
      check("stop_mic_fall", mic_clk, 0);
      check("stop_busy_hold", busy, 1);
      @(negedge clk);
      #1;
      check("stop_busy_low", busy, 0);
      check("stop_idle_state", dbg_state, 0);
      repeat (80) @(negedge clk);
      #1;
      check("stop_no_partial", pcm_valid, 0);
      check("stop_q_empty", exp_q.size(), 0);
      check("idle_overrun_sticky", overrun, 1);
      check("idle_mic_low", mic_clk, 0);

      // New start clears overrun.
      do_start(1'b0);
      check("restart_overrun", overrun, 0);
      check("restart_busy", busy, 1);
      stop = 1'b1;
      @(negedge clk);
      #1;
      stop = 1'b0;
      n = 0;
      while (busy && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("restart_stop_idle", busy, 0);

      // Start and stop together in idle: start wins.
      do_start(1'b1);
      check("start_wins_busy", busy, 1);
      check("start_wins_state", dbg_state, 1);

      // Reset in the middle of RUN with a held sample and overrun set.
      pcm_ready = 1'b0;
      drive_bits(8'hFF, 8'h00, 8);
      drive_bits(8'hFF, 8'h00, 8);
      drive_bits(8'h0F, 8'h00, 8);
      drive_bits(8'hFF, 8'h00, 8);
      @(negedge clk);
      #1;
      check("pre_rst_valid", pcm_valid, 1);
      check("pre_rst_data", pcm_data, pick(4'd4, 8'h04));
      check("pre_rst_overrun", overrun, 1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_mic_clk", mic_clk, 0);
      check("mid_rst_valid", pcm_valid, 0);
      check("mid_rst_data", pcm_data, 0);
      check("mid_rst_overrun", overrun, 0);
      rst = 1'b0;
      pcm_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("final_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #400000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "time limit");
   end

endmodule
